// File: rtl/pulse_pkg.sv
// Shared types for the output pulse stretcher.
package pulse_pkg;

    typedef enum logic [1:0] {IDLE, HIGH, LOW} pulse_state_t;

endpackage

// File: rtl/pulse_stretch.sv
// Stretches single-cycle event strobes into pulses with a guaranteed high time and low gap,
// queueing events that arrive while a pulse is in progress.
module pulse_stretch
    import pulse_pkg::*;
#(
    parameter int HIGH_CYCLES = 5,
    parameter int LOW_CYCLES  = 5,
    parameter int MAX_PENDING = 3
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             trigger,
    output logic                             pulse,
    output logic                             busy,
    output logic [$clog2(MAX_PENDING+1)-1:0] pending,
    output logic                             dropped
);

    localparam int MAX_CYCLES = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);
    localparam int PW = $clog2(MAX_PENDING + 1);
    localparam logic [CW-1:0] HIGH_LOAD = CW'(HIGH_CYCLES - 1);
    localparam logic [CW-1:0] LOW_LOAD  = CW'(LOW_CYCLES - 1);
    localparam logic [PW-1:0] PEND_MAX  = PW'(MAX_PENDING);

    pulse_state_t  state, nextState;
    logic [CW-1:0] cnt, nextCnt;
    logic [PW-1:0] nextPending;
    logic          nextDropped;
    logic          queueEvent;

    // On a LOW exit the incoming event is consumed directly, so only the queue dequeue
    // (if any) changes pending; every other in-flight event goes through the queue.
    always_comb begin
        nextState   = state;
        nextCnt     = cnt;
        nextPending = pending;
        nextDropped = 1'b0;
        queueEvent  = 1'b0;
        case (state)
            IDLE: begin
                if (trigger) begin
                    nextState = HIGH;
                    nextCnt   = HIGH_LOAD;
                end
            end
            HIGH: begin
                queueEvent = trigger;
                if (cnt != '0) begin
                    nextCnt = cnt - 1'b1;
                end else begin
                    nextState = LOW;
                    nextCnt   = LOW_LOAD;
                end
            end
            LOW: begin
                if (cnt != '0) begin
                    nextCnt    = cnt - 1'b1;
                    queueEvent = trigger;
                end else if (pending != '0) begin
                    nextState = HIGH;
                    nextCnt   = HIGH_LOAD;
                    if (!trigger) nextPending = pending - 1'b1;
                end else if (trigger) begin
                    nextState = HIGH;
                    nextCnt   = HIGH_LOAD;
                end else begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
        if (queueEvent) begin
            if (pending < PEND_MAX) nextPending = pending + 1'b1;
            else                    nextDropped = 1'b1;
        end
    end

    // pulse is registered from the next state so the pin never sees decode glitches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            pending <= '0;
            dropped <= 1'b0;
            pulse   <= 1'b0;
        end else begin
            state   <= nextState;
            cnt     <= nextCnt;
            pending <= nextPending;
            dropped <= nextDropped;
            pulse   <= (nextState == HIGH);
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_pulse_stretch.sv
// Self-checking bench: two pulse_stretch instances (default and 1/1 timing) against a
// schedule-based model that tracks pulse start times arithmetically.
module tb_pulse_stretch;

    logic       clk = 1'b0;
    logic       rst;
    logic       trig0, trig1;
    logic       pulse0, busy0, dropped0;
    logic       pulse1, busy1, dropped1;
    logic [1:0] pending0, pending1;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;

    int hCfg[2] = '{5, 1};
    int lCfg[2] = '{5, 1};
    int mCfg[2] = '{3, 3};

    int lastStart[2];
    int expPulse[2], expBusy[2], expDrop[2], expPend[2];
    int highCnt[2], busyCnt[2], dropCnt[2], riseCnt[2], maxPend[2], prevPulse[2];

    pulse_stretch #(.HIGH_CYCLES(5), .LOW_CYCLES(5), .MAX_PENDING(3)) dut0 (
        .clk(clk), .rst(rst), .trigger(trig0), .pulse(pulse0),
        .busy(busy0), .pending(pending0), .dropped(dropped0)
    );

    pulse_stretch #(.HIGH_CYCLES(1), .LOW_CYCLES(1), .MAX_PENDING(3)) dut1 (
        .clk(clk), .rst(rst), .trigger(trig1), .pulse(pulse1),
        .busy(busy1), .pending(pending1), .dropped(dropped1)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int required);
        compared++;
        if (actual != required) begin
            mismatched++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, required);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 2; i++) begin
            lastStart[i] = -1000000;
            expPulse[i] = 0; expBusy[i] = 0; expDrop[i] = 0; expPend[i] = 0;
        end
    endtask

    // Every accepted event owns a start edge; queued starts are spaced by one full period,
    // so pending is just how many starts still lie in the future.
    task automatic modelStep(input int i, input bit trig, input int t);
        int p, ls, pend, cur;
        p  = hCfg[i] + lCfg[i];
        ls = lastStart[i];
        pend = (ls > t) ? (ls - t - 1) / p + 1 : 0;
        expDrop[i] = 0;
        if (trig) begin
            if (pend < mCfg[i]) ls = (t > ls + p) ? t : ls + p;
            else                expDrop[i] = 1;
        end
        pend = (ls > t) ? (ls - t - 1) / p + 1 : 0;
        cur  = (ls <= t) ? ls : ls - pend * p;
        expPend[i]  = pend;
        expPulse[i] = ((t - cur) < hCfg[i]) ? 1 : 0;
        expBusy[i]  = ((t - cur) < p) ? 1 : 0;
        lastStart[i] = ls;
    endtask

    task automatic clearCounts();
        for (int i = 0; i < 2; i++) begin
            highCnt[i] = 0; busyCnt[i] = 0; dropCnt[i] = 0; riseCnt[i] = 0; maxPend[i] = 0;
        end
    endtask

    task automatic applyStimulus(input bit a, input bit b);
        @(negedge clk);
        trig0 = a;
        trig1 = b;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0);
    endtask

    // Single compare process: advance the model on each edge, then check both DUTs.
    always begin
        bit t0, t1, r;
        int dP[2], dB[2], dD[2], dN[2];
        @(posedge clk);
        t0 = trig0; t1 = trig1; r = rst;
        cyc++;
        if (r) modelReset();
        else begin
            modelStep(0, t0, cyc);
            modelStep(1, t1, cyc);
        end
        #1;
        dP[0] = int'(pulse0); dB[0] = int'(busy0); dD[0] = int'(dropped0); dN[0] = int'(pending0);
        dP[1] = int'(pulse1); dB[1] = int'(busy1); dD[1] = int'(dropped1); dN[1] = int'(pending1);
        for (int i = 0; i < 2; i++) begin
            checkOutput($sformatf("pulse[%0d]", i),   dP[i], expPulse[i]);
            checkOutput($sformatf("busy[%0d]", i),    dB[i], expBusy[i]);
            checkOutput($sformatf("pending[%0d]", i), dN[i], expPend[i]);
            checkOutput($sformatf("dropped[%0d]", i), dD[i], expDrop[i]);
            highCnt[i] += dP[i];
            busyCnt[i] += dB[i];
            dropCnt[i] += dD[i];
            if (dP[i] == 1 && prevPulse[i] == 0) riseCnt[i]++;
            prevPulse[i] = dP[i];
            if (dN[i] > maxPend[i]) maxPend[i] = dN[i];
        end
    end

    initial begin
        rst = 1'b1; trig0 = 1'b0; trig1 = 1'b0;
        modelReset();
        clearCounts();
        prevPulse[0] = 0; prevPulse[1] = 0;
        repeat (3) @(negedge clk);
        checkOutput("reset pulse", int'(pulse0), 0);
        checkOutput("reset busy", int'(busy0), 0);
        checkOutput("reset pending", int'(pending0), 0);
        checkOutput("reset dropped", int'(dropped0), 0);
        rst = 1'b0;
        idle(2);

        $display("[TB] single event");
        clearCounts();
        applyStimulus(1'b1, 1'b0);
        idle(15);
        checkOutput("single high cycles", highCnt[0], 5);
        checkOutput("single busy cycles", busyCnt[0], 10);
        checkOutput("single pulses", riseCnt[0], 1);
        checkOutput("single max pending", maxPend[0], 0);

        $display("[TB] back-to-back");
        clearCounts();
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        idle(25);
        checkOutput("b2b high cycles", highCnt[0], 10);
        checkOutput("b2b busy cycles", busyCnt[0], 20);
        checkOutput("b2b pulses", riseCnt[0], 2);
        checkOutput("b2b max pending", maxPend[0], 1);

        $display("[TB] overflow");
        clearCounts();
        repeat (6) applyStimulus(1'b1, 1'b0);
        idle(50);
        checkOutput("overflow pulses", riseCnt[0], 4);
        checkOutput("overflow high cycles", highCnt[0], 20);
        checkOutput("overflow drops", dropCnt[0], 2);
        checkOutput("overflow max pending", maxPend[0], 3);

        $display("[TB] exit coincidence, empty queue");
        clearCounts();
        applyStimulus(1'b1, 1'b0);
        idle(9);
        applyStimulus(1'b1, 1'b0);
        idle(25);
        checkOutput("exit0 pulses", riseCnt[0], 2);
        checkOutput("exit0 busy cycles", busyCnt[0], 20);
        checkOutput("exit0 max pending", maxPend[0], 0);

        $display("[TB] exit coincidence, full queue");
        clearCounts();
        repeat (4) applyStimulus(1'b1, 1'b0);
        idle(6);
        applyStimulus(1'b1, 1'b0);
        idle(60);
        checkOutput("exit3 pulses", riseCnt[0], 5);
        checkOutput("exit3 drops", dropCnt[0], 0);
        checkOutput("exit3 max pending", maxPend[0], 3);

        $display("[TB] reset mid-pulse");
        repeat (3) applyStimulus(1'b1, 1'b0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        trig0 = 1'b0;
        #1;
        checkOutput("async reset pulse", int'(pulse0), 0);
        checkOutput("async reset busy", int'(busy0), 0);
        checkOutput("async reset pending", int'(pending0), 0);
        checkOutput("async reset dropped", int'(dropped0), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clearCounts();
        idle(20);
        checkOutput("post-reset pulses", riseCnt[0], 0);
        checkOutput("post-reset busy cycles", busyCnt[0], 0);

        $display("[TB] 1/1 timing sweep");
        clearCounts();
        repeat (4) applyStimulus(1'b0, 1'b1);
        idle(15);
        checkOutput("sweep pulses", riseCnt[1], 4);
        checkOutput("sweep high cycles", highCnt[1], 4);
        checkOutput("sweep busy cycles", busyCnt[1], 8);
        checkOutput("sweep drops", dropCnt[1], 0);
        checkOutput("sweep max pending", maxPend[1], 2);

        $display("[TB] random traffic");
        for (int k = 0; k < 3000; k++)
            applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 0);
        idle(60);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pulse_stretch.md
# pulse_stretch

Output-side conditioning block: the counterpart to input debouncing. It turns single-cycle internal event strobes into clean, minimum-width pulses on slow external indicators and pins (LEDs, scope probes, SPI-board status lines). Each output pulse has a guaranteed high time followed by a guaranteed low gap. Events that arrive while a pulse is in progress are queued up to a limit, so every accepted event produces its own visible pulse. The block sits between core logic and the top-level output pins, in the same clock domain as the logic driving `trigger`.

## Interface
Parameters:
- `HIGH_CYCLES`, 5, number of cycles `pulse` is held high per event; must be ≥1.
- `LOW_CYCLES`, 5, minimum number of cycles `pulse` is held low between consecutive pulses; must be ≥1.
- `MAX_PENDING`, 3, maximum number of queued events; must be ≥1.

Ports:
- `clk` input 1: the single clock; all logic is on its rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `trigger` input 1: event strobe. It is synchronous to `clk`, and each cycle it is high counts as one event.
- `pulse` output 1: the stretched output, registered.
- `busy` output 1: high whenever the state is not IDLE.
- `pending` output `$clog2(MAX_PENDING+1)`: number of queued events not yet emitted.
- `dropped` output 1: one-cycle strobe, raised when an event is discarded because the queue is full.

## Operation
- State machine with states IDLE, HIGH and LOW. A down-counter `cnt` is sized `$clog2(max(HIGH_CYCLES,LOW_CYCLES)+1)` bits.
- IDLE:
  - If `trigger` is high, go to HIGH and load `cnt = HIGH_CYCLES-1`.
  - Otherwise stay in IDLE.
- HIGH:
  - `pulse` is 1.
  - While `cnt != 0`, decrement `cnt`.
  - When `cnt == 0`, go to LOW and load `cnt = LOW_CYCLES-1`.
- LOW:
  - `pulse` is 0.
  - While `cnt != 0`, decrement `cnt`.
  - When `cnt == 0`, go to HIGH (load `HIGH_CYCLES-1`) if there is work, otherwise go to IDLE.
  - There is work if `pending > 0`, in which case `pending` decrements, or if `trigger` is high this cycle, in which case that event is consumed directly and `pending` is unchanged.
- Event handling in HIGH, or in LOW when LOW is not consuming the event on its exit cycle:
  - If `pending < MAX_PENDING`, `pending` increments.
  - Otherwise the event is discarded and `dropped` = 1 on the next cycle.
- Simultaneous event and dequeue on a LOW exit with `pending > 0`:
  - `pending` is unchanged (−1 for the dequeue, +1 for the new event).
  - No drop occurs, even when `pending == MAX_PENDING`.
- `pending` never exceeds `MAX_PENDING` and never underflows.
- `busy = (state != IDLE)`, decoded combinationally from the state register.

## Timing
- Reset values: `pulse` = 0, `busy` = 0, `pending` = 0, `dropped` = 0, state = IDLE, `cnt` = 0.
- Assertion of `rst` clears all of the above immediately, including in the middle of a pulse. Queued events are lost and `dropped` is not raised for them.
- Latency: if `trigger` is sampled high at edge N while IDLE, `pulse` rises after edge N and is high for exactly `HIGH_CYCLES` cycles.
- After a pulse, `pulse` is low for exactly `LOW_CYCLES` cycles when back-to-back work exists. The period under a sustained queue is `HIGH_CYCLES + LOW_CYCLES`.
- From IDLE, the earliest next pulse is immediate. The IDLE state adds no extra low cycle beyond `LOW_CYCLES`.
- `pending` and `dropped` update on the same edge that samples `trigger`.
- `pulse` never glitches: it is driven directly from a flop, or from a decode of the state register that is flop-equivalent.

## Structure
- Shared package `pulse_pkg`: `typedef enum logic [1:0] {IDLE, HIGH, LOW} pulse_state_t`.
- Everything else (counter widths, load values) is a local parameter derived from the block's own parameters.
- No sub-module: the single counter and the queue counter are inlined in one `always_ff` / `always_comb` pair.

## Test plan
- **Single event:** defaults; one-cycle `trigger` from idle → `pulse` high for 5 cycles, then 0; `busy` high for 10 cycles total; `pending` stays 0.
- **Back-to-back:** `trigger` for 2 consecutive cycles → two 5-high pulses separated by exactly 5 low cycles; `pending` goes 0→1→0.
- **Overflow:** `MAX_PENDING=3`; `trigger` held for 6 cycles from idle → `pending` reaches 3; `dropped` pulses on the 5th- and 6th-event cycles; exactly 4 output pulses are produced.
- **Exit coincidence:** `trigger` on the last LOW cycle with `pending=0` → the next HIGH starts immediately and `pending` stays 0. With `pending=3`, `pending` stays 3 and `dropped` stays 0.
- **Reset mid-pulse:** assert `rst` asynchronously 2 cycles into HIGH with `pending=2` → `pulse`, `busy` and `pending` are 0 before the next edge; after release, stays IDLE with no pulses.
- **Parameter sweep:** `HIGH_CYCLES=1`, `LOW_CYCLES=1`; `trigger` held for 4 cycles → `pulse` alternates 1,0,1,0,… for 4 high cycles; no drops.
